// File: rtl/uart_regs_pkg.sv
// UART CSR block register map and field constants.
// Shared by the CSR top and the bench-facing documentation of the map.
package uart_regs_pkg;

  localparam int DATA_ADDR   = 'h04;
  localparam int STAT_ADDR   = 'h0C;
  localparam int CTRL_ADDR   = 'h10;
  localparam int LP_ADDR     = 'h14;
  localparam int INSTAT_ADDR = 'h20;
  localparam int INTEN_ADDR  = 'h24;
  localparam int ID_ADDR     = 'h40;

  localparam int DATA_FERR_LSB = 16;
  localparam int DATA_PERR_LSB = 17;

  localparam int STAT_BUSY_LSB    = 2;
  localparam int STAT_RXE_LSB     = 4;
  localparam int STAT_TXF_LSB     = 8;
  localparam int STAT_RXLVL_LSB   = 16;
  localparam int STAT_RXLVL_WIDTH = 8;
  localparam int STAT_TXLVL_LSB   = 24;
  localparam int STAT_TXLVL_WIDTH = 8;

  localparam int CTRL_BAUD_LSB   = 0;
  localparam int CTRL_BAUD_WIDTH = 2;
  localparam int CTRL_TXEN_LSB   = 4;
  localparam int CTRL_RXEN_LSB   = 5;
  localparam int CTRL_TXST_LSB   = 6;
  localparam logic [31:0] CTRL_MASK  = 32'h0000_0033;
  localparam logic [31:0] CTRL_RESET = 32'h0;

  localparam int LP_DIV_LSB   = 0;
  localparam int LP_DIV_WIDTH = 8;
  localparam int LP_EN_LSB    = 31;
  localparam logic [31:0] LP_MASK  = 32'h8000_00FF;
  localparam logic [31:0] LP_RESET = 32'h0;

  localparam int INSTAT_TX_LSB    = 0;
  localparam int INSTAT_RX_LSB    = 1;
  localparam int INSTAT_RXOVR_LSB = 2;
  localparam int INSTAT_TXOVR_LSB = 3;
  localparam int INSTAT_WIDTH     = 4;
  localparam logic [31:0] INSTAT_MASK  = 32'h0000_000F;
  localparam logic [31:0] INSTAT_RESET = 32'h0;

  localparam int INTEN_WIDTH = 4;
  localparam logic [31:0] INTEN_MASK  = 32'h0000_000F;
  localparam logic [31:0] INTEN_RESET = 32'h0;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_regs_fifo.sv
// UART CSR block: local-bus register map, TX/RX FIFOs,
// W1C sticky interrupt status and a registered irq.
module uart_regs_fifo
  import uart_regs_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 32,
  parameter int          BASE_ADDR  = 0,
  parameter int          FIFO_WIDTH = 8,
  parameter int          TX_DEPTH   = 16,
  parameter int          RX_DEPTH   = 16,
  parameter logic [31:0] ID_VALUE   = 32'hCAFE0666
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lb_waddr,
  input  logic [DATA_WIDTH-1:0] lb_wdata,
  input  logic                  lb_wen,
  input  logic [3:0]            lb_wstrb,
  output logic                  lb_wready,
  input  logic [ADDR_WIDTH-1:0] lb_raddr,
  input  logic                  lb_ren,
  output logic [DATA_WIDTH-1:0] lb_rdata,
  output logic                  lb_rvalid,
  output logic [FIFO_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [FIFO_WIDTH-1:0] rx_data,
  input  logic                  rx_ferr,
  input  logic                  rx_perr,
  input  logic                  rx_valid,
  input  logic                  busy,
  output logic [1:0]            ctrl_baud,
  output logic                  ctrl_txen,
  output logic                  ctrl_rxen,
  output logic                  ctrl_txst,
  output logic [7:0]            lp_div,
  output logic                  lp_en,
  output logic                  irq
);

  localparam int FW  = FIFO_WIDTH;
  localparam int TLW = $clog2(TX_DEPTH) + 1;
  localparam int RLW = $clog2(RX_DEPTH) + 1;

  function automatic logic hit(input logic [ADDR_WIDTH-1:0] a,
                               input int off);
    return a == ADDR_WIDTH'(BASE_ADDR + off);
  endfunction

  logic                     wb0;
  logic                     w_data;
  logic                     w_ctrl;
  logic                     w_lp0;
  logic                     w_lp3;
  logic                     w_instat;
  logic                     w_inten;
  logic                     r_data;
  logic [INSTAT_WIDTH-1:0]  instat;
  logic [INTEN_WIDTH-1:0]   inten;
  logic [INSTAT_WIDTH-1:0]  set;
  logic [INSTAT_WIDTH-1:0]  clr;
  logic [DATA_WIDTH-1:0]    rd;

  logic            tx_full;
  logic            tx_empty;
  logic [TLW-1:0]  tx_level;
  logic            tx_pop;
  logic            tx_push;
  logic            tx_ovr;
  logic            tx_drain;

  logic            rx_full;
  logic            rx_empty;
  logic [RLW-1:0]  rx_level;
  logic [FW+1:0]   rx_head;
  logic            rx_req;
  logic            rx_pop;
  logic            rx_push;
  logic            rx_ovr;

  logic            unused_bits;

  assign unused_bits = ^{lb_wdata, lb_wstrb};
  assign lb_wready   = 1'b1;

  assign wb0      = lb_wen & lb_wstrb[0];
  assign w_data   = wb0 & hit(lb_waddr, DATA_ADDR);
  assign w_ctrl   = wb0 & hit(lb_waddr, CTRL_ADDR);
  assign w_lp0    = wb0 & hit(lb_waddr, LP_ADDR);
  assign w_lp3    = lb_wen & lb_wstrb[3] & hit(lb_waddr, LP_ADDR);
  assign w_instat = wb0 & hit(lb_waddr, INSTAT_ADDR);
  assign w_inten  = wb0 & hit(lb_waddr, INTEN_ADDR);
  assign r_data   = lb_ren & hit(lb_raddr, DATA_ADDR);

  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_push  = w_data & (~tx_full | tx_pop);
  assign tx_ovr   = w_data & tx_full & ~tx_pop;
  assign tx_drain = tx_pop & (tx_level == TLW'(1)) & ~tx_push;

  assign rx_req  = rx_valid & ctrl_rxen;
  assign rx_pop  = r_data & ~rx_empty;
  assign rx_push = rx_req & (~rx_full | rx_pop);
  assign rx_ovr  = rx_req & rx_full & ~rx_pop;

  always_comb begin
    set = '0;
    set[INSTAT_TX_LSB]    = tx_drain;
    set[INSTAT_RX_LSB]    = rx_push;
    set[INSTAT_RXOVR_LSB] = rx_ovr;
    set[INSTAT_TXOVR_LSB] = tx_ovr;
    clr = w_instat ? lb_wdata[INSTAT_WIDTH-1:0] : '0;
  end

  sync_fifo #(.WIDTH(FW), .DEPTH(TX_DEPTH)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (lb_wdata[FW-1:0]),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  sync_fifo #(.WIDTH(FW + 2), .DEPTH(RX_DEPTH)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   ({rx_perr, rx_ferr, rx_data}),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  always_comb begin
    rd = '0;
    unique case (1'b1)
      hit(lb_raddr, DATA_ADDR): begin
        if (!rx_empty) begin
          rd[FW-1:0]          = rx_head[FW-1:0];
          rd[DATA_FERR_LSB]   = rx_head[FW];
          rd[DATA_PERR_LSB]   = rx_head[FW+1];
        end
      end
      hit(lb_raddr, STAT_ADDR): begin
        rd[STAT_BUSY_LSB] = busy;
        rd[STAT_RXE_LSB]  = rx_empty;
        rd[STAT_TXF_LSB]  = tx_full;
        rd[STAT_RXLVL_LSB +: STAT_RXLVL_WIDTH] =
          STAT_RXLVL_WIDTH'(rx_level);
        rd[STAT_TXLVL_LSB +: STAT_TXLVL_WIDTH] =
          STAT_TXLVL_WIDTH'(tx_level);
      end
      hit(lb_raddr, CTRL_ADDR): begin
        rd[CTRL_BAUD_LSB +: CTRL_BAUD_WIDTH] = ctrl_baud;
        rd[CTRL_TXEN_LSB] = ctrl_txen;
        rd[CTRL_RXEN_LSB] = ctrl_rxen;
      end
      hit(lb_raddr, LP_ADDR): begin
        rd[LP_DIV_LSB +: LP_DIV_WIDTH] = lp_div;
        rd[LP_EN_LSB] = lp_en;
      end
      hit(lb_raddr, INSTAT_ADDR): rd[INSTAT_WIDTH-1:0] = instat;
      hit(lb_raddr, INTEN_ADDR):  rd[INTEN_WIDTH-1:0]  = inten;
      hit(lb_raddr, ID_ADDR):     rd = DATA_WIDTH'(ID_VALUE);
      default: rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_baud <= CTRL_RESET[CTRL_BAUD_LSB +: CTRL_BAUD_WIDTH];
      ctrl_txen <= CTRL_RESET[CTRL_TXEN_LSB];
      ctrl_rxen <= CTRL_RESET[CTRL_RXEN_LSB];
      ctrl_txst <= 1'b0;
      lp_div    <= LP_RESET[LP_DIV_LSB +: LP_DIV_WIDTH];
      lp_en     <= LP_RESET[LP_EN_LSB];
      instat    <= INSTAT_RESET[INSTAT_WIDTH-1:0];
      inten     <= INTEN_RESET[INTEN_WIDTH-1:0];
      irq       <= 1'b0;
      lb_rvalid <= 1'b0;
      lb_rdata  <= '0;
    end else begin
      if (w_ctrl) begin
        ctrl_baud <= lb_wdata[CTRL_BAUD_LSB +: CTRL_BAUD_WIDTH];
        ctrl_txen <= lb_wdata[CTRL_TXEN_LSB];
        ctrl_rxen <= lb_wdata[CTRL_RXEN_LSB];
      end
      ctrl_txst <= w_ctrl & lb_wdata[CTRL_TXST_LSB];
      if (w_lp0) lp_div <= lb_wdata[LP_DIV_LSB +: LP_DIV_WIDTH];
      if (w_lp3) lp_en  <= lb_wdata[LP_EN_LSB];
      if (w_inten) inten <= lb_wdata[INTEN_WIDTH-1:0];
      // Set is applied after clear so a coincident event is not lost.
      instat    <= (instat & ~clr) | set;
      irq       <= |(instat & inten);
      lb_rvalid <= lb_ren;
      if (lb_ren) lb_rdata <= rd;
    end
  end

endmodule

// File: tb/tb_uart_regs_fifo.sv
// Self-checking bench for uart_regs_fifo: directed register scenarios
// followed by random bus/core traffic against a queue-based model.
module tb_uart_regs_fifo;

  localparam int FW  = 8;
  localparam int TXD = 16;
  localparam int RXD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] waddr;
  logic [31:0] wdata;
  logic        wen;
  logic [3:0]  wstrb;
  logic        wready;
  logic [15:0] raddr;
  logic        ren;
  logic [31:0] rdata;
  logic        rvalid;
  logic [FW-1:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [FW-1:0] rx_data;
  logic        rx_ferr;
  logic        rx_perr;
  logic        rx_valid;
  logic        busy;
  logic [1:0]  ctrl_baud;
  logic        ctrl_txen;
  logic        ctrl_rxen;
  logic        ctrl_txst;
  logic [7:0]  lp_div;
  logic        lp_en;
  logic        irq;

  always #5 clk = ~clk;

  uart_regs_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .lb_waddr  (waddr),
    .lb_wdata  (wdata),
    .lb_wen    (wen),
    .lb_wstrb  (wstrb),
    .lb_wready (wready),
    .lb_raddr  (raddr),
    .lb_ren    (ren),
    .lb_rdata  (rdata),
    .lb_rvalid (rvalid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_ferr   (rx_ferr),
    .rx_perr   (rx_perr),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .ctrl_baud (ctrl_baud),
    .ctrl_txen (ctrl_txen),
    .ctrl_rxen (ctrl_rxen),
    .ctrl_txst (ctrl_txst),
    .lp_div    (lp_div),
    .lp_en     (lp_en),
    .irq       (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [FW-1:0] txq[$];
  logic [FW+1:0] rxq[$];
  logic [1:0]  m_baud;
  logic        m_txen, m_rxen, m_txst, m_lpen, m_irq, m_rvalid;
  logic [7:0]  m_div;
  logic [3:0]  m_instat, m_inten;
  logic [31:0] m_rdata;

  logic [15:0] addrs [8] = '{16'h04, 16'h08, 16'h0C, 16'h10,
                             16'h14, 16'h20, 16'h24, 16'h40};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      16'h04: if (rxq.size() != 0) begin
        r[FW-1:0] = rxq[0][FW-1:0];
        r[16] = rxq[0][FW];
        r[17] = rxq[0][FW+1];
      end
      16'h0C: r = {8'(txq.size()), 8'(rxq.size()), 7'b0,
                   1'(txq.size() == TXD), 3'b0, 1'(rxq.size() == 0),
                   1'b0, busy, 2'b0};
      16'h10: r = {26'b0, m_rxen, m_txen, 2'b0, m_baud};
      16'h14: r = {m_lpen, 23'b0, m_div};
      16'h20: r = {28'b0, m_instat};
      16'h24: r = {28'b0, m_inten};
      16'h40: r = 32'hCAFE0666;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_baud = 0; m_txen = 0; m_rxen = 0; m_txst = 0;
    m_div = 0; m_lpen = 0; m_instat = 0; m_inten = 0;
    m_irq = 0; m_rvalid = 0; m_rdata = 0;
  endtask

  task automatic tick();
    logic [31:0] exp_rd;
    logic [3:0]  set, clr;
    logic        tx_was;
    logic        wb0;
    exp_rd = model_read(raddr);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      wb0 = wen && wstrb[0];
      m_irq = |(m_instat & m_inten);
      m_rvalid = ren;
      if (ren) m_rdata = exp_rd;
      set = '0;
      tx_was = txq.size() != 0;
      if (tx_ready && txq.size() != 0) void'(txq.pop_front());
      if (wb0 && waddr == 16'h04) begin
        if (txq.size() < TXD) txq.push_back(wdata[FW-1:0]);
        else set[3] = 1'b1;
      end
      if (tx_was && txq.size() == 0) set[0] = 1'b1;
      if (ren && raddr == 16'h04 && rxq.size() != 0)
        void'(rxq.pop_front());
      if (rx_valid && m_rxen) begin
        if (rxq.size() < RXD) begin
          rxq.push_back({rx_perr, rx_ferr, rx_data});
          set[1] = 1'b1;
        end else set[2] = 1'b1;
      end
      m_txst = wb0 && waddr == 16'h10 && wdata[6];
      if (wb0 && waddr == 16'h10) begin
        m_baud = wdata[1:0]; m_txen = wdata[4]; m_rxen = wdata[5];
      end
      if (wb0 && waddr == 16'h14) m_div = wdata[7:0];
      if (wen && wstrb[3] && waddr == 16'h14) m_lpen = wdata[31];
      if (wb0 && waddr == 16'h24) m_inten = wdata[3:0];
      clr = (wb0 && waddr == 16'h20) ? wdata[3:0] : 4'h0;
      m_instat = (m_instat & ~clr) | set;
    end
    #1;
    check("rvalid", 32'(rvalid), 32'(m_rvalid));
    check("rdata", rdata, m_rdata);
    check("irq", 32'(irq), 32'(m_irq));
    check("wready", 32'(wready), 32'h1);
    check("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
    if (txq.size() != 0) check("tx_data", 32'(tx_data), 32'(txq[0]));
    check("ctrl_out", {16'b0, ctrl_baud, ctrl_txen, ctrl_rxen,
                       ctrl_txst, lp_en, lp_div},
          {16'b0, m_baud, m_txen, m_rxen, m_txst, m_lpen, m_div});
  endtask

  task automatic idle();
    wen = 0; ren = 0; rx_valid = 0; wstrb = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    waddr = a; wdata = d; wstrb = s; wen = 1;
    tick();
    wen = 0;
  endtask

  task automatic rd(input logic [15:0] a);
    raddr = a; ren = 1;
    tick();
    ren = 0;
  endtask

  task automatic push(input logic [FW-1:0] d, input logic fe,
                      input logic pe);
    rx_data = d; rx_ferr = fe; rx_perr = pe; rx_valid = 1;
    tick();
    rx_valid = 0;
  endtask

  initial begin
    rst = 1; idle(); waddr = 0; wdata = 0; raddr = 0;
    tx_ready = 0; rx_data = 0; rx_ferr = 0; rx_perr = 0; busy = 0;
    model_reset();
    tick(); tick();
    rst = 0;
    tick();

    foreach (addrs[i]) begin
      rd(addrs[i]);
      if (addrs[i] == 16'h0C) check("rst_stat", rdata, 32'h10);
      if (addrs[i] == 16'h10) check("rst_ctrl", rdata, 32'h0);
      if (addrs[i] == 16'h40) check("id", rdata, 32'hCAFE0666);
    end

    for (int i = 0; i < 16; i++) wr(16'h04, 32'h41 + i, 4'h1);
    rd(16'h0C);
    check("tx_full_stat", rdata, 32'h1000_0110);
    wr(16'h04, 32'h51, 4'h1);
    rd(16'h20);
    check("txovr", rdata, 32'h8);
    rd(16'h0C);
    check("tx_lvl_hold", rdata, 32'h1000_0110);
    tx_ready = 1;
    for (int i = 0; i < 16; i++) begin
      check("tx_order", 32'(tx_data), 32'h41 + i);
      tick();
    end
    tick();
    tx_ready = 0;
    rd(16'h20);
    check("tx_drain", rdata, 32'h9);
    wr(16'h20, 32'hF, 4'h1);

    wr(16'h10, 32'h20, 4'h1);
    push(8'h55, 1'b1, 1'b0);
    rd(16'h20);
    check("rx_flag", rdata, 32'h2);
    rd(16'h04);
    check("rx_data", rdata, 32'h10055);
    rd(16'h04);
    check("rx_empty_rd", rdata, 32'h0);
    rd(16'h0C);
    check("rxe", rdata, 32'h10);
    wr(16'h20, 32'hF, 4'h1);

    for (int i = 0; i < 16; i++) push(8'(i), 1'b0, 1'(i & 1));
    raddr = 16'h04; ren = 1;
    rx_data = 8'hAA; rx_ferr = 0; rx_perr = 0; rx_valid = 1;
    tick();
    idle();
    rd(16'h20);
    check("no_rxovr", rdata, 32'h2);
    rd(16'h0C);
    check("rx_lvl16", rdata, 32'h0010_0000);
    push(8'hBB, 1'b0, 1'b0);
    rd(16'h20);
    check("rxovr", rdata, 32'h6);
    wr(16'h20, 32'hF, 4'h1);
    repeat (16) rd(16'h04);

    wr(16'h24, 32'h2, 4'h1);
    push(8'h33, 1'b0, 1'b0);
    tick();
    check("irq_set", 32'(irq), 32'h1);
    waddr = 16'h20; wdata = 32'h2; wstrb = 4'h1; wen = 1;
    rx_data = 8'h34; rx_valid = 1;
    tick();
    idle();
    rd(16'h20);
    check("set_wins", rdata, 32'h2);
    wr(16'h20, 32'h2, 4'h1);
    tick();
    check("irq_clr", 32'(irq), 32'h0);
    repeat (2) rd(16'h04);

    wr(16'h10, 32'h7F, 4'h1);
    check("txst_pulse", 32'(ctrl_txst), 32'h1);
    tick();
    check("txst_clear", 32'(ctrl_txst), 32'h0);
    rd(16'h10);
    check("ctrl_rd", rdata, 32'h33);
    wr(16'h10, 32'h0, 4'h0);
    rd(16'h10);
    check("strb0_ign", rdata, 32'h33);

    for (int c = 0; c < 1500; c++) begin
      wen = 1'($urandom_range(0, 1));
      waddr = ($urandom_range(0, 1) == 0) ? 16'h04
                                          : addrs[$urandom_range(0, 7)];
      wdata = $urandom;
      wstrb = 4'($urandom);
      ren = 1'($urandom_range(0, 1));
      raddr = ($urandom_range(0, 2) == 0) ? 16'h04
                                          : addrs[$urandom_range(0, 7)];
      tx_ready = ($urandom_range(0, 3) == 0);
      rx_valid = 1'($urandom_range(0, 1));
      rx_data = 8'($urandom);
      rx_ferr = 1'($urandom);
      rx_perr = 1'($urandom);
      busy = 1'($urandom);
      tick();
    end
    idle();
    busy = 0;
    tx_ready = 0;

    wr(16'h10, 32'h20, 4'h1);
    for (int i = 0; i < 5; i++) wr(16'h04, 32'h60 + i, 4'h1);
    push(8'h77, 1'b0, 1'b0);
    wr(16'h14, 32'h8000_0012, 4'hF);
    rst = 1;
    wen = 1; waddr = 16'h04; wdata = 32'h99; wstrb = 4'h1;
    tick();
    idle();
    rst = 0;
    rd(16'h0C);
    check("rst_mid_stat", rdata, 32'h10);
    rd(16'h14);
    check("rst_mid_lp", rdata, 32'h0);
    rd(16'h20);
    check("rst_mid_instat", rdata, 32'h0);
    check("rst_mid_txv", 32'(tx_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
